// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, engine state types and burst legality helper
// for the axi4_slave_mem slave memory.
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_burst_addr.sv
// Combinational next-beat address and burst legality for one AXI4 engine.
module axi4_burst_addr
  import axi4_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  legal_o
);

  localparam int unsigned SHIFT = $clog2(STRB_WIDTH);

  burst_e                burst;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] span;
  logic [ADDR_WIDTH-1:0] mask;

  always_comb begin
    burst   = burst_e'(burst_i);
    incr    = addr_i + ADDR_WIDTH'(STRB_WIDTH);
    span    = (ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << SHIFT;
    mask    = span - ADDR_WIDTH'(1);
    legal_o = (burst != BURST_RSVD) && ((burst != BURST_WRAP) || wrap_len_ok(len_i));
    case (burst)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = incr;
      BURST_WRAP:  next_addr_o = (addr_i & ~mask) | (incr & mask);
      default:     next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: independent write (AW/W/B) and read (AR/R) engines
// over a byte-strobed word array; all channel outputs are registered.
module axi4_slave_mem
  import axi4_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [1:0]            AWBURST,
  input  logic [ID_WIDTH-1:0]   AWID,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_WIDTH-1:0]   BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [1:0]            ARBURST,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int unsigned SHIFT = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------- write engine ----------------
  wr_state_e             wr_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [7:0]            aw_len_q;
  logic [1:0]            aw_burst_q;
  logic [ID_WIDTH-1:0]   aw_id_q;
  logic [7:0]            w_beat_q;
  logic                  w_slv_q, w_dec_q, w_over_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [1:0]            bresp_q;

  logic [ADDR_WIDTH-1:0] w_next, w_word;
  logic                  w_legal, w_hs, w_in_range, w_we, w_slv_d, w_dec_d;

  axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_wr_addr (
    .addr_i      (aw_addr_q),
    .len_i       (aw_len_q),
    .burst_i     (aw_burst_q),
    .next_addr_o (w_next),
    .legal_o     (w_legal)
  );

  always_comb begin
    w_hs       = WVALID && wready_q;
    w_word     = aw_addr_q >> SHIFT;
    w_in_range = w_word < ADDR_WIDTH'(MEM_DEPTH);
    // Beats past AWLEN are swallowed, so they neither write nor add DECERR.
    w_we       = w_hs && !ARESET && w_legal && w_in_range && !w_over_q;
    w_slv_d    = w_slv_q || !w_legal || (WLAST && (w_beat_q < aw_len_q)) ||
                 (!WLAST && (w_over_q || (w_beat_q == aw_len_q)));
    w_dec_d    = w_dec_q || (w_legal && !w_in_range && !w_over_q);
  end

  always_ff @(posedge ACLK) begin
    if (w_we) begin
      for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
        if (WSTRB[b]) mem[w_word[IDX_W-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_q       <= W_IDLE;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_burst_q <= '0;
      aw_id_q    <= '0;
      w_beat_q   <= '0;
      w_slv_q    <= 1'b0;
      w_dec_q    <= 1'b0;
      w_over_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= '0;
    end else begin
      case (wr_q)
        W_IDLE: begin
          if (AWVALID && awready_q) begin
            aw_addr_q  <= AWADDR;
            aw_len_q   <= AWLEN;
            aw_burst_q <= AWBURST;
            aw_id_q    <= AWID;
            w_beat_q   <= '0;
            w_slv_q    <= 1'b0;
            w_dec_q    <= 1'b0;
            w_over_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wr_q       <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            aw_addr_q <= w_next;
            w_slv_q   <= w_slv_d;
            w_dec_q   <= w_dec_d;
            if (!w_over_q) w_beat_q <= w_beat_q + 8'd1;
            if (!WLAST && (w_beat_q == aw_len_q)) w_over_q <= 1'b1;
            if (WLAST) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= aw_id_q;
              bresp_q  <= w_slv_d ? RESP_SLVERR : (w_dec_d ? RESP_DECERR : RESP_OKAY);
              wr_q     <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wr_q      <= W_IDLE;
          end
        end
        default: wr_q <= W_IDLE;
      endcase
    end
  end

  // ---------------- read engine ----------------
  rd_state_e             rd_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]            ar_len_q;
  logic [1:0]            ar_burst_q;
  logic [7:0]            r_beat_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic [ADDR_WIDTH-1:0] r_addr_in, r_next, r_fetch, r_word;
  logic [7:0]            r_len_in;
  logic [1:0]            r_burst_in;
  logic                  r_legal, r_in_range;
  logic [DATA_WIDTH-1:0] r_data_d;
  logic [1:0]            r_resp_d;

  // In R_IDLE the calculator sees the incoming AR request so beat 0 can be
  // fetched on the handshake; in R_DATA it sees the captured burst.
  always_comb begin
    r_addr_in  = (rd_q == R_IDLE) ? ARADDR  : ar_addr_q;
    r_len_in   = (rd_q == R_IDLE) ? ARLEN   : ar_len_q;
    r_burst_in = (rd_q == R_IDLE) ? ARBURST : ar_burst_q;
  end

  axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_rd_addr (
    .addr_i      (r_addr_in),
    .len_i       (r_len_in),
    .burst_i     (r_burst_in),
    .next_addr_o (r_next),
    .legal_o     (r_legal)
  );

  always_comb begin
    r_fetch    = (rd_q == R_IDLE) ? ARADDR : r_next;
    r_word     = r_fetch >> SHIFT;
    r_in_range = r_word < ADDR_WIDTH'(MEM_DEPTH);
    r_data_d   = '0;
    r_resp_d   = RESP_OKAY;
    if (!r_legal) begin
      r_resp_d = RESP_SLVERR;
    end else if (!r_in_range) begin
      r_resp_d = RESP_DECERR;
    end else begin
      r_data_d = mem[r_word[IDX_W-1:0]];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_q       <= R_IDLE;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_burst_q <= '0;
      r_beat_q   <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      case (rd_q)
        R_IDLE: begin
          if (ARVALID && arready_q) begin
            ar_addr_q  <= ARADDR;
            ar_len_q   <= ARLEN;
            ar_burst_q <= ARBURST;
            r_beat_q   <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rid_q      <= ARID;
            rdata_q    <= r_data_d;
            rresp_q    <= r_resp_d;
            rlast_q    <= (ARLEN == 8'd0);
            rd_q       <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (rvalid_q && RREADY) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rd_q      <= R_IDLE;
            end else begin
              ar_addr_q <= r_next;
              r_beat_q  <= r_beat_q + 8'd1;
              rdata_q   <= r_data_d;
              rresp_q   <= r_resp_d;
              rlast_q   <= ((r_beat_q + 8'd1) == ar_len_q);
            end
          end
        end
        default: rd_q <= R_IDLE;
      endcase
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed self-checking bench for axi4_slave_mem (32-bit data, 1024 words).
module tb_axi4_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] AWADDR = '0;
  logic [7:0]  AWLEN = '0;
  logic [1:0]  AWBURST = '0;
  logic [3:0]  AWID = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [1:0]  ARBURST = '0;
  logic [3:0]  ARID = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];
  int          rd_n;

  axi4_slave_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(1024)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST), .AWID(AWID),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST), .ARID(ARID),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  // Channel drivers; every task starts and ends 1ns after a rising edge.
  task automatic do_aw(input logic [31:0] a, input logic [7:0] len,
                       input logic [1:0] b, input logic [3:0] id);
    int t = 0;
    while (AWREADY !== 1'b1 && t < 50) begin @(posedge ACLK); #1; t++; end
    if (t >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL aw_wait: AWREADY=%b required 1", AWREADY);
    end
    AWADDR = a; AWLEN = len; AWBURST = b; AWID = id; AWVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [7:0] len,
                       input logic [1:0] b, input logic [3:0] id);
    int t = 0;
    while (ARREADY !== 1'b1 && t < 50) begin @(posedge ACLK); #1; t++; end
    if (t >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL ar_wait: ARREADY=%b required 1", ARREADY);
    end
    ARADDR = a; ARLEN = len; ARBURST = b; ARID = id; ARVALID = 1'b1;
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic last);
    int   t  = 0;
    logic hs = 1'b0;
    WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
    while (!hs && t < 50) begin
      hs = (WREADY === 1'b1);
      @(posedge ACLK); #1; t++;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    if (!hs) begin
      n_checks++; n_fail++;
      $display("FAIL w_wait: WREADY=%b required 1", WREADY);
    end
  endtask

  task automatic do_b(output logic [3:0] id, output logic [1:0] resp);
    int   t  = 0;
    logic hs = 1'b0;
    id = '0; resp = '0;
    BREADY = 1'b1;
    while (!hs && t < 50) begin
      hs = (BVALID === 1'b1); id = BID; resp = BRESP;
      @(posedge ACLK); #1; t++;
    end
    BREADY = 1'b0;
    if (!hs) begin
      n_checks++; n_fail++;
      $display("FAIL b_wait: BVALID=%b required 1", BVALID);
    end
  endtask

  task automatic collect_r(input int nbeats);
    int t = 0;
    rd_n = 0;
    RREADY = 1'b1;
    while (rd_n < nbeats && t < 100) begin
      if (RVALID === 1'b1) begin
        rd_data[rd_n] = RDATA; rd_resp[rd_n] = RRESP;
        rd_last[rd_n] = RLAST; rd_id[rd_n]   = RID;
        rd_n++;
      end
      @(posedge ACLK); #1; t++;
    end
    RREADY = 1'b0;
    if (rd_n < nbeats) begin
      n_checks++; n_fail++;
      $display("FAIL r_wait: got %0d beats required %0d", rd_n, nbeats);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge ACLK);
    #1;
    n_checks++;
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST});
    end
    n_checks++;
    if ({BID, BRESP, RID, RRESP, RDATA} !== 44'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", {BID, BRESP, RID, RRESP, RDATA});
    end
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    n_checks++;
    if ({AWREADY, ARREADY} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 11", {AWREADY, ARREADY});
    end
  endtask

  task automatic test_incr;
    logic [3:0] bid;
    logic [1:0] bresp;
    do_aw(32'h100, 8'd3, 2'b01, 4'd3);
    n_checks++;
    if (WREADY !== 1'b1) begin n_fail++; $display("FAIL incr_wready: got %b required 1", WREADY); end
    for (int i = 0; i < 4; i++) do_w(32'hA0 + i, 4'hF, i == 3);
    n_checks++;
    if (BVALID !== 1'b1) begin n_fail++; $display("FAIL incr_bvalid_timing: got %b required 1", BVALID); end
    do_b(bid, bresp);
    n_checks++;
    if (bid !== 4'd3) begin n_fail++; $display("FAIL incr_bid: got %h required 3", bid); end
    n_checks++;
    if (bresp !== 2'b00) begin n_fail++; $display("FAIL incr_bresp: got %b required 00", bresp); end
    n_checks++;
    if (AWREADY !== 1'b1) begin n_fail++; $display("FAIL incr_awready_after_b: got %b required 1", AWREADY); end
    do_ar(32'h100, 8'd3, 2'b01, 4'd5);
    n_checks++;
    if (RVALID !== 1'b1) begin n_fail++; $display("FAIL incr_rvalid_timing: got %b required 1", RVALID); end
    collect_r(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_data[i] !== 32'hA0 + i || rd_last[i] !== (i == 3) || rd_id[i] !== 4'd5 ||
          rd_resp[i] !== 2'b00) begin
        n_fail++;
        $display("FAIL incr_read beat %0d: got data=%h last=%b id=%h resp=%b required data=%h last=%b id=5 resp=00",
                 i, rd_data[i], rd_last[i], rd_id[i], rd_resp[i], 32'hA0 + i, (i == 3));
      end
    end
    n_checks++;
    if (ARREADY !== 1'b1) begin n_fail++; $display("FAIL incr_arready_after_r: got %b required 1", ARREADY); end
  endtask

  task automatic test_wrap;
    logic [31:0] exp [4] = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
    do_ar(32'h108, 8'd3, 2'b10, 4'd1);
    collect_r(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_data[i] !== exp[i] || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL wrap_read beat %0d: got data=%h resp=%b last=%b required data=%h resp=00 last=%b",
                 i, rd_data[i], rd_resp[i], rd_last[i], exp[i], (i == 3));
      end
    end
  endtask

  task automatic test_strobe;
    logic [3:0] bid;
    logic [1:0] bresp;
    do_aw(32'h200, 8'd0, 2'b01, 4'd1);
    do_w(32'hFFFF_FFFF, 4'hF, 1'b1);
    do_b(bid, bresp);
    do_aw(32'h200, 8'd0, 2'b01, 4'd2);
    do_w(32'h1234_5678, 4'h5, 1'b1);
    do_b(bid, bresp);
    n_checks++;
    if (bid !== 4'd2 || bresp !== 2'b00) begin
      n_fail++; $display("FAIL strobe_b: got id=%h resp=%b required id=2 resp=00", bid, bresp);
    end
    do_ar(32'h200, 8'd0, 2'b01, 4'd0);
    collect_r(1);
    n_checks++;
    if (rd_data[0] !== 32'hFF34_FF78) begin
      n_fail++; $display("FAIL strobe_data: got %h required ff34ff78", rd_data[0]);
    end
  endtask

  task automatic test_decerr;
    logic [3:0] bid;
    logic [1:0] bresp;
    do_aw(32'hFFC, 8'd0, 2'b01, 4'd4);
    do_w(32'hCAFE_0001, 4'hF, 1'b1);
    do_b(bid, bresp);
    do_ar(32'hFFC, 8'd1, 2'b01, 4'd7);
    collect_r(2);
    n_checks++;
    if (rd_data[0] !== 32'hCAFE_0001 || rd_resp[0] !== 2'b00) begin
      n_fail++; $display("FAIL decerr_beat0: got data=%h resp=%b required cafe0001 00", rd_data[0], rd_resp[0]);
    end
    n_checks++;
    if (rd_data[1] !== 32'h0 || rd_resp[1] !== 2'b11 || rd_last[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL decerr_beat1: got data=%h resp=%b last=%b required 0 11 1",
               rd_data[1], rd_resp[1], rd_last[1]);
    end
    do_aw(32'hFFC, 8'd1, 2'b01, 4'd8);
    do_w(32'h1111_1111, 4'hF, 1'b0);
    do_w(32'h2222_2222, 4'hF, 1'b1);
    do_b(bid, bresp);
    n_checks++;
    if (bresp !== 2'b11) begin n_fail++; $display("FAIL decerr_bresp: got %b required 11", bresp); end
    do_ar(32'hFFC, 8'd0, 2'b01, 4'd0);
    collect_r(1);
    n_checks++;
    if (rd_data[0] !== 32'h1111_1111 || rd_resp[0] !== 2'b00) begin
      n_fail++; $display("FAIL decerr_inrange_write: got %h %b required 11111111 00", rd_data[0], rd_resp[0]);
    end
  endtask

  task automatic test_slverr;
    logic [3:0] bid;
    logic [1:0] bresp;
    do_aw(32'h100, 8'd0, 2'b11, 4'd9);
    do_w(32'hDEAD_BEEF, 4'hF, 1'b1);
    do_b(bid, bresp);
    n_checks++;
    if (bresp !== 2'b10 || bid !== 4'd9) begin
      n_fail++; $display("FAIL slverr_rsvd_b: got id=%h resp=%b required id=9 resp=10", bid, bresp);
    end
    do_ar(32'h100, 8'd0, 2'b01, 4'd0);
    collect_r(1);
    n_checks++;
    if (rd_data[0] !== 32'hA0) begin
      n_fail++; $display("FAIL slverr_mem_unchanged: got %h required 000000a0", rd_data[0]);
    end
    do_ar(32'h100, 8'd2, 2'b10, 4'd6);
    collect_r(3);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rd_resp[i] !== 2'b10 || rd_data[i] !== 32'h0 || rd_last[i] !== (i == 2)) begin
        n_fail++;
        $display("FAIL slverr_wrap_len beat %0d: got resp=%b data=%h last=%b required 10 0 %b",
                 i, rd_resp[i], rd_data[i], rd_last[i], (i == 2));
      end
    end
  endtask

  task automatic test_early_wlast;
    logic [3:0] bid;
    logic [1:0] bresp;
    do_aw(32'h300, 8'd3, 2'b01, 4'd6);
    do_w(32'h1, 4'hF, 1'b0);
    do_w(32'h2, 4'hF, 1'b1);
    n_checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b10 || BID !== 4'd6) begin
      n_fail++;
      $display("FAIL early_wlast_b: got valid=%b resp=%b id=%h required 1 10 6", BVALID, BRESP, BID);
    end
    do_b(bid, bresp);
    do_aw(32'h400, 8'd0, 2'b01, 4'd7);
    do_w(32'h3, 4'hF, 1'b0);
    do_w(32'h4, 4'hF, 1'b1);
    do_b(bid, bresp);
    n_checks++;
    if (bresp !== 2'b10) begin n_fail++; $display("FAIL overrun_bresp: got %b required 10", bresp); end
  endtask

  task automatic test_rready_toggle;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic [31:0] p_data;
    logic [1:0]  p_resp;
    logic        p_last, p_stall;
    int          beat = 0;
    do_aw(32'h500, 8'd7, 2'b01, 4'd2);
    for (int i = 0; i < 8; i++) do_w(32'hB0 + i, 4'hF, i == 7);
    do_b(bid, bresp);
    do_ar(32'h500, 8'd7, 2'b01, 4'd9);
    p_stall = 1'b0; p_data = '0; p_resp = '0; p_last = 1'b0;
    for (int cyc = 0; cyc < 40 && beat < 8; cyc++) begin
      RREADY = (cyc % 2 == 1);
      if (p_stall) begin
        n_checks++;
        if (RVALID !== 1'b1 || RDATA !== p_data || RRESP !== p_resp || RLAST !== p_last) begin
          n_fail++;
          $display("FAIL stall_hold cyc %0d: got v=%b d=%h r=%b l=%b required 1 %h %b %b",
                   cyc, RVALID, RDATA, RRESP, RLAST, p_data, p_resp, p_last);
        end
      end
      if (RVALID === 1'b1 && RREADY) begin
        n_checks++;
        if (RDATA !== 32'hB0 + beat || RLAST !== (beat == 7) || RID !== 4'd9) begin
          n_fail++;
          $display("FAIL toggle_beat %0d: got d=%h l=%b id=%h required d=%h l=%b id=9",
                   beat, RDATA, RLAST, RID, 32'hB0 + beat, (beat == 7));
        end
        beat++;
      end
      p_stall = (RVALID === 1'b1) && !RREADY;
      p_data = RDATA; p_resp = RRESP; p_last = RLAST;
      @(posedge ACLK); #1;
    end
    RREADY = 1'b0;
    n_checks++;
    if (beat != 8) begin n_fail++; $display("FAIL toggle_count: got %0d beats required 8", beat); end
  endtask

  task automatic test_reset_mid_burst;
    int n = 0;
    int t = 0;
    do_ar(32'h500, 8'd7, 2'b01, 4'd4);
    RREADY = 1'b1;
    while (n < 3 && t < 50) begin
      if (RVALID === 1'b1) n++;
      @(posedge ACLK); #1; t++;
    end
    RREADY = 1'b0;
    n_checks++;
    if (RDATA !== 32'hB3 || RVALID !== 1'b1) begin
      n_fail++; $display("FAIL midburst_beat3: got v=%b d=%h required 1 000000b3", RVALID, RDATA);
    end
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    n_checks++;
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} !== 6'b0 ||
        {BID, BRESP, RID, RRESP, RDATA} !== 44'h0) begin
      n_fail++;
      $display("FAIL midburst_reset_outputs: got ctrl=%b data=%h required 0",
               {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST}, {BID, BRESP, RID, RRESP, RDATA});
    end
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    n_checks++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      n_fail++; $display("FAIL midburst_release: got arready=%b rvalid=%b required 1 0", ARREADY, RVALID);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_strobe();
    test_decerr();
    test_slverr();
    test_early_wlast();
    test_rready_toggle();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
